port_arbiter: RTL and testbench
===============================

// Module: port_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the 8-bit output PORT of cpu_main.
//  NREQ requesters (CPU core, debug/monitor logic, ...) each offer one byte.
//  One winner at a time drives PORT for HOLD_CYC cycles, qualified by PORT_STB.
//  Sits between the requesters and the PORT pins.
// PARAMETERS
//  NREQ      4      number of requesters (>=2)
//  HOLD_CYC  3      cycles PORT_STB stays high per transfer (>=1)
//  PORT_RST  8'h00  PORT value at reset
// PORTS
//  CLK       in   1          clock, rising edge
//  RST_N     in   1          asynchronous reset, active-low
//  REQ       in   NREQ       per-requester transfer request, level
//  DATA      in   NREQ*8     byte per requester; requester i on [8i+7:8i]
//  LOCK      in   NREQ       ownership-retain request (only with PORT_ARB_LOCK_EN)
//  ACK       out  NREQ       one-hot, one-cycle pulse: byte accepted
//  PORT      out  8          registered output byte
//  PORT_STB  out  1          high while PORT holds a fresh transfer
//  BUSY      out  1          high when state != IDLE
//  OWNER     out  clog2(NREQ)  index of last/current grantee
// BEHAVIOUR
//  Reset (RST_N low, async, takes effect immediately, including mid-HOLD):
//   PORT=PORT_RST, ACK=0, PORT_STB=0, BUSY=0, OWNER=0, state=IDLE.
//   Round-robin pointer LAST=NREQ-1, so requester 0 has first priority.
//  FSM with two states, IDLE and HOLD:
//   IDLE, REQ==0: stay in IDLE; all outputs hold (PORT keeps last byte).
//   IDLE, REQ!=0: winner w = first set REQ bit scanning LAST+1, LAST+2, ...
//     modulo NREQ. On the same edge: PORT<=DATA[w], ACK<=onehot(w),
//     OWNER<=w, PORT_STB<=1, cnt<=HOLD_CYC-1, state<=HOLD.
//   HOLD: ACK<=0 (pulse is exactly 1 cycle). cnt decrements each cycle.
//     When cnt==0: PORT_STB<=0, LAST<=OWNER, state<=IDLE.
//  Latency and throughput:
//   ACK and PORT update 1 edge after REQ is seen in IDLE.
//   Back-to-back transfers start every HOLD_CYC+1 cycles.
//  Handshake rules:
//   Requester holds REQ and DATA stable until it sees ACK.
//   REQ still high in the cycle after ACK counts as a new request.
//   REQ changes during HOLD are ignored; sampling happens only in IDLE.
//   Dropping REQ before ACK withdraws the request; no side effects.
//  Boundaries:
//   Pointer wraps from NREQ-1 to 0.
//   A single active requester is re-granted every HOLD_CYC+1 cycles.
//   PORT is never cleared except by reset.
//   DATA of non-winners is ignored.
// CONFIGURATION
//  PORT_ARB_LOCK_EN defined: LOCK port exists.
//   At HOLD exit, if LOCK[OWNER]=1, LAST is NOT advanced.
//   The next IDLE arbitration grants OWNER first if REQ[OWNER]=1;
//   otherwise normal round-robin from the unchanged LAST.
//  PORT_ARB_LOCK_EN undefined: LOCK port absent; pure round-robin as above.
// TESTING (NREQ=4, HOLD_CYC=3, PORT_RST=8'h00)
//  1 RST_N=0 at any time -> PORT=00, ACK=0, PORT_STB=0, BUSY=0, OWNER=0.
//  2 REQ=0100, DATA[2]=A5 -> next edge: ACK=0100 for 1 cycle, PORT=A5,
//    OWNER=2, PORT_STB high 3 cycles, then idle with PORT=A5.
//  3 REQ=1111 held, DATA[i]=10+i -> PORT=10,11,12,13,10, one per 4 cycles.
//  4 RST_N low during 2nd HOLD cycle -> PORT=00, PORT_STB=0 before next edge;
//    after release, REQ=1111 grants requester 0 first.
//  5 REQ=0001 held after ACK, REQ[1] rises during HOLD -> next grant is 1,
//    then 0.
//  6 (LOCK_EN) REQ=1010, LOCK=0010 -> grants 1,1,1; LOCK=0 -> next grant 3.

Source files
------------

// File: rtl/port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : port_arbiter
//  Purpose  : Round-robin arbiter/sequencer for the 8-bit output PORT.
//             NREQ requesters each offer one byte; one winner at a time
//             drives PORT for HOLD_CYC cycles, qualified by port_stb.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREQ      number of requesters (>=2)
//    HOLD_CYC  cycles port_stb stays high per transfer (>=1)
//    PORT_RST  port value at reset
//  Ports
//    clk       in   1              clock, rising edge
//    rst_n     in   1              asynchronous reset, active-low
//    req       in   NREQ           per-requester transfer request (level)
//    data      in   NREQ*8         byte per requester, i on [8i+7:8i]
//    lock      in   NREQ           ownership-retain request (PORT_ARB_LOCK_EN)
//    ack       out  NREQ           one-hot, one-cycle accept pulse
//    port      out  8              registered output byte
//    port_stb  out  1              high while port holds a fresh transfer
//    busy      out  1              high while not idle
//    owner     out  clog2(NREQ)    index of last/current grantee
//  Configuration
//    PORT_ARB_LOCK_EN  when defined, adds the lock port: an owner holding
//                      lock at the end of its transfer is re-granted first.
// ============================================================================
module port_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         HOLD_CYC = 3,
  parameter logic [7:0] PORT_RST = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*8-1:0]         data,
`ifdef PORT_ARB_LOCK_EN
  input  logic [NREQ-1:0]           lock,
`endif
  output logic [NREQ-1:0]           ack,
  output logic [7:0]                port,
  output logic                      port_stb,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [NREQ-1:0] ack_d;
  logic [7:0]      port_d;
  logic            stb_d;
  logic [IW-1:0]   owner_d;

  logic [IW-1:0]   winner;
  logic            found;
  logic [IW-1:0]   idx;
  logic [7:0]      win_byte;

`ifdef PORT_ARB_LOCK_EN
  // Set when the previous owner asked to retain the port; gives it first
  // claim at the next arbitration without disturbing the round-robin pointer.
  logic            locked_q, locked_d;
`endif

  // Winner selection: scan last+1, last+2, ... modulo NREQ.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = '0;
`ifdef PORT_ARB_LOCK_EN
    if (locked_q && req[owner]) begin
      winner = owner;
      found  = 1'b1;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Byte mux for the selected requester; other requesters' data is ignored.
  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) begin
        win_byte = data[i*8 +: 8];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    port_d  = port;
    stb_d   = port_stb;
    owner_d = owner;
`ifdef PORT_ARB_LOCK_EN
    locked_d = locked_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          port_d        = win_byte;
          ack_d[winner] = 1'b1;
          owner_d       = winner;
          stb_d         = 1'b1;
          cnt_d         = CW'(HOLD_CYC - 1);
          state_d       = HOLD;
`ifdef PORT_ARB_LOCK_EN
          locked_d      = 1'b0;
`endif
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          stb_d   = 1'b0;
          state_d = IDLE;
`ifdef PORT_ARB_LOCK_EN
          if (lock[owner]) begin
            locked_d = 1'b1;
          end else begin
            last_d   = owner;
          end
`else
          last_d  = owner;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IW'(NREQ - 1);
      cnt_q    <= '0;
      ack      <= '0;
      port     <= PORT_RST;
      port_stb <= 1'b0;
      owner    <= '0;
`ifdef PORT_ARB_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ack      <= ack_d;
      port     <= port_d;
      port_stb <= stb_d;
      owner    <= owner_d;
`ifdef PORT_ARB_LOCK_EN
      locked_q <= locked_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_port_arbiter
//  Purpose  : Directed self-checking bench for port_arbiter
//             (NREQ=4, HOLD_CYC=3, PORT_RST=8'h00).
//  Revision : 1.0  initial release
// ============================================================================
module tb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic [7:0]  port;
  logic        port_stb;
  logic        busy;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  port_arbiter #(
    .NREQ     (4),
    .HOLD_CYC (3),
    .PORT_RST (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
`ifdef PORT_ARB_LOCK_EN
    .lock     (lock),
`endif
    .ack      (ack),
    .port     (port),
    .port_stb (port_stb),
    .busy     (busy),
    .owner    (owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    data  = 32'h0;
    lock  = 4'b0000;

    // Reset state
    tick();
    tick();
    chk("rst_port",  port,     32'h00);
    chk("rst_ack",   ack,      32'h0);
    chk("rst_stb",   port_stb, 32'h0);
    chk("rst_busy",  busy,     32'h0);
    chk("rst_owner", owner,    32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 32'h0);

    // Single request from requester 2
    data = 32'h44_A5_22_11;
    req  = 4'b0100;
    tick();
    chk("t2_ack",   ack,      32'b0100);
    chk("t2_port",  port,     32'hA5);
    chk("t2_owner", owner,    32'd2);
    chk("t2_stb",   port_stb, 32'h1);
    chk("t2_busy",  busy,     32'h1);
    req = 4'b0000;
    tick();
    chk("t2_ack_pulse", ack,      32'h0);
    chk("t2_stb_c1",    port_stb, 32'h1);
    tick();
    chk("t2_stb_c2",    port_stb, 32'h1);
    tick();
    chk("t2_stb_off",   port_stb, 32'h0);
    chk("t2_busy_off",  busy,     32'h0);
    chk("t2_port_keep", port,     32'hA5);
    tick();
    chk("t2_port_idle", port,     32'hA5);
    chk("t2_ack_idle",  ack,      32'h0);

    // Reset asserted while idle acts without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_port",  port,  32'h00);
    chk("async_rst_owner", owner, 32'h0);
    tick();
    rst_n = 1'b1;

    // All requesters held: 10,11,12,13,10 one per 4 cycles
    data = 32'h13_12_11_10;
    req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t3_port",  port,  32'h10 + (g % 4));
      chk("t3_ack",   ack,   32'h1 << (g % 4));
      chk("t3_owner", owner, g % 4);
      if (g < 4) begin
        tick();
        tick();
        chk("t3_stb_hi", port_stb, 32'h1);
        tick();
        chk("t3_stb_lo", port_stb, 32'h0);
      end
    end

    // Reset during the 2nd HOLD cycle
    tick();
    chk("t4_busy_pre", busy, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_port",  port,     32'h00);
    chk("t4_stb",   port_stb, 32'h0);
    chk("t4_busy",  busy,     32'h0);
    chk("t4_owner", owner,    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t4_regrant_ack",  ack,  32'b0001);
    chk("t4_regrant_port", port, 32'h10);

    // Requester 0 holds, requester 1 rises during HOLD
    req = 4'b0001;
    tick();
    req = 4'b0011;
    chk("t5_hold_ack", ack, 32'h0);
    tick();
    chk("t5_hold_owner", owner, 32'h0);
    tick();
    chk("t5_idle_busy", busy, 32'h0);
    tick();
    chk("t5_g1_ack",   ack,   32'b0010);
    chk("t5_g1_owner", owner, 32'd1);
    chk("t5_g1_port",  port,  32'h11);
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    chk("t5_g0_ack",   ack,   32'b0001);
    chk("t5_g0_owner", owner, 32'd0);
    chk("t5_g0_port",  port,  32'h10);
    // Single active requester re-granted every 4 cycles
    tick();
    tick();
    tick();
    chk("t5_gap_ack", ack, 32'h0);
    tick();
    chk("t5_single_ack", ack, 32'b0001);
    req = 4'b0000;
    tick();
    tick();
    tick();
    chk("t5_end_busy", busy, 32'h0);

`ifdef PORT_ARB_LOCK_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req  = 4'b1010;
    lock = 4'b0010;
    tick();
    chk("t6_g1", owner, 32'd1);
    tick();
    tick();
    tick();
    tick();
    chk("t6_g2", owner, 32'd1);
    tick();
    tick();
    tick();
    tick();
    chk("t6_g3", owner, 32'd1);
    lock = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    chk("t6_g4", owner, 32'd3);
    chk("t6_g4_ack", ack, 32'b1000);
    req = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
